// File: rtl/argmax_select.sv
// Sequential argmax over NUM_VALUES signed neuron outputs. The inputs are
// snapshotted on start, then scanned one per cycle. Ties keep the lowest index.

module argmax_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     dout <= '0;
    else if (load) dout <= din;
  end
endmodule

module argmax_select #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  NUM_VALUES  = 10,
  localparam int INDEX_WIDTH = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NUM_VALUES-1:0][DATA_WIDTH-1:0]  values,
  output logic [INDEX_WIDTH-1:0]                 max_index,
  output logic signed [DATA_WIDTH-1:0]           max_value,
  output logic                                   result_valid,
  output logic                                   busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST    = INDEX_WIDTH'(NUM_VALUES - 1);
  localparam logic [DATA_WIDTH-1:0]  MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                               state;
  logic [INDEX_WIDTH-1:0]               counter;
  logic [DATA_WIDTH-1:0]                run_max;
  logic [INDEX_WIDTH-1:0]               run_idx;
  logic [NUM_VALUES-1:0][DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0]                cur;
  logic                                 load;
  logic                                 gt;

  assign load = (state == IDLE) && start;

  // Snapshot registers, one per class, loaded only on the start edge
  for (genvar i = 0; i < NUM_VALUES; i++) begin : g_lane
    argmax_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .din   (values[i]),
      .dout  (snap[i])
    );
  end

  // Explicit compare mux avoids indexing with a counter wider than the array
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_VALUES; i++)
      if (counter == INDEX_WIDTH'(i)) cur = snap[i];
  end

  assign gt = $signed(cur) > $signed(run_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            counter <= '0;
            run_max <= MOST_NEG;
            run_idx <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (gt) begin
            run_max <= cur;
            run_idx <= counter;
          end
          if (counter == LAST) begin
            max_value <= gt ? cur : run_max;
            max_index <= gt ? counter : run_idx;
            counter   <= '0;
            state     <= DONE;
          end else begin
            counter <= counter + INDEX_WIDTH'(1);
          end
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == SCAN);
  assign result_valid = (state == DONE);
endmodule

// File: tb/tb_argmax_select.sv
// Directed bench for argmax_select: a 10-value and a 1-value instance.
`timescale 1ns/1ps
module tb_argmax_select;
  logic                  clock;
  logic                  reset;
  logic                  start;
  logic [9:0][31:0]      values;
  logic [3:0]            max_index;
  logic signed [31:0]    max_value;
  logic                  result_valid;
  logic                  busy;

  logic                  start1;
  logic [0:0][31:0]      values1;
  logic [0:0]            max_index1;
  logic signed [31:0]    max_value1;
  logic                  result_valid1;
  logic                  busy1;

  int vectors;
  int miscompares;
  int vec [10];

  argmax_select #(.DATA_WIDTH(32), .NUM_VALUES(10)) dut (
    .clock(clock), .reset(reset), .start(start), .values(values),
    .max_index(max_index), .max_value(max_value),
    .result_valid(result_valid), .busy(busy)
  );

  argmax_select #(.DATA_WIDTH(32), .NUM_VALUES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .values(values1),
    .max_index(max_index1), .max_value(max_value1),
    .result_valid(result_valid1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_vec();
    for (int i = 0; i < 10; i++) values[i] = 32'(vec[i]);
  endtask

  // Ticks until result_valid, bounded; returns total edges including those already taken
  task automatic count_to_valid(input int already, output int edges);
    edges = already;
    while (!result_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || max_index !== 4'd0 || max_value !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b valid=%b idx=%0d val=%0d, required 0/0/0/0",
               busy, result_valid, max_index, max_value);
    end
    vectors++;
    if (busy1 !== 1'b0 || result_valid1 !== 1'b0 || max_index1 !== 1'b0 || max_value1 !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_state_n1: busy=%b valid=%b idx=%0d val=%0d, required 0/0/0/0",
               busy1, result_valid1, max_index1, max_value1);
    end
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: busy=%b valid=%b, required 0/0", busy, result_valid);
    end
  endtask

  task automatic test_basic();
    int edges;
    vec = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    apply_vec();
    start = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_load: busy=%b valid=%b, required 1/0", busy, result_valid);
    end
    count_to_valid(1, edges);
    vectors++;
    if (edges !== 11 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: edges=%0d busy=%b, required 11/0", edges, busy);
    end
    vectors++;
    if (max_index !== 4'd2 || max_value !== 32'sd7) begin
      miscompares++;
      $display("FAIL basic_tie: idx=%0d val=%0d, required 2/7", max_index, max_value);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_negative();
    int edges;
    for (int i = 0; i < 10; i++) vec[i] = 32'h8000_0000;
    apply_vec();
    start = 1'b1;
    count_to_valid(0, edges);
    vectors++;
    if (edges !== 11 || max_index !== 4'd0 || max_value !== 32'sh8000_0000) begin
      miscompares++;
      $display("FAIL all_most_neg: edges=%0d idx=%0d val=%h, required 11/0/80000000",
               edges, max_index, max_value);
    end
    start = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) vec[i] = -4;
    apply_vec();
    start = 1'b1;
    count_to_valid(0, edges);
    vectors++;
    if (edges !== 11 || max_index !== 4'd0 || max_value !== -32'sd4) begin
      miscompares++;
      $display("FAIL all_minus4: edges=%0d idx=%0d val=%0d, required 11/0/-4",
               edges, max_index, max_value);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_snapshot_hold();
    int edges;
    int unstable;
    for (int i = 0; i < 10; i++) vec[i] = i;
    vec[9] = 100;
    apply_vec();
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) vec[i] = 500;
    apply_vec();
    count_to_valid(1, edges);
    vectors++;
    if (edges !== 11 || max_index !== 4'd9 || max_value !== 32'sd100) begin
      miscompares++;
      $display("FAIL snapshot: edges=%0d idx=%0d val=%0d, required 11/9/100",
               edges, max_index, max_value);
    end
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (result_valid !== 1'b1 || busy !== 1'b0 || max_index !== 4'd9 || max_value !== 32'sd100)
        unstable++;
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL done_hold: %0d unstable cycles, required 0", unstable);
    end
  endtask

  task automatic test_drop_restart();
    int edges;
    start = 1'b0;
    tick();
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || max_index !== 4'd9 || max_value !== 32'sd100) begin
      miscompares++;
      $display("FAIL drop_start: valid=%b busy=%b idx=%0d val=%0d, required 0/0/9/100",
               result_valid, busy, max_index, max_value);
    end
    vec = '{-8, -3, -20, -3, -9, -100, -4, -5, -6, -7};
    apply_vec();
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    count_to_valid(3, edges);
    vectors++;
    if (edges !== 11 || max_index !== 4'd1 || max_value !== -32'sd3) begin
      miscompares++;
      $display("FAIL restart: edges=%0d idx=%0d val=%0d, required 11/1/-3",
               edges, max_index, max_value);
    end
    tick();
    vectors++;
    if (result_valid !== 1'b0 || max_index !== 4'd1) begin
      miscompares++;
      $display("FAIL done_exit: valid=%b idx=%0d, required 0/1", result_valid, max_index);
    end
  endtask

  task automatic test_reset_mid_scan();
    int edges;
    int stray;
    vec = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};
    apply_vec();
    start = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || max_index !== 4'd0 || max_value !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_mid_scan: busy=%b valid=%b idx=%0d val=%0d, required 0/0/0/0",
               busy, result_valid, max_index, max_value);
    end
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (result_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL idle_after_reset: %0d active cycles, required 0", stray);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    count_to_valid(0, edges);
    vectors++;
    if (edges !== 11 || max_index !== 4'd3 || max_value !== 32'sd50) begin
      miscompares++;
      $display("FAIL start_on_release: edges=%0d idx=%0d val=%0d, required 11/3/50",
               edges, max_index, max_value);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int edges;
    values1[0] = -32'sd9;
    start1 = 1'b1;
    edges = 0;
    while (!result_valid1 && edges < 40) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges !== 2 || max_index1 !== 1'b0 || max_value1 !== -32'sd9) begin
      miscompares++;
      $display("FAIL single_value: edges=%0d idx=%0d val=%0d, required 2/0/-9",
               edges, max_index1, max_value1);
    end
    start1 = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    values = '0;
    values1 = '0;
    #2;
    test_reset();
    test_basic();
    test_negative();
    test_snapshot_hold();
    test_drop_restart();
    test_reset_mid_scan();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
